// File: rtl/seg_sched_pkg.sv
// Shared types and the round-robin successor search for the display scheduler.
package seg_sched_pkg;

  typedef enum logic [1:0] {IDLE, SHOW, ALERT} sched_state_t;

  // First valid index after sel, wrapping modulo n; returns sel itself when it is the only valid one.
  function automatic logic [2:0] rr_next(input logic [7:0] vld, input logic [2:0] sel, input int n);
    logic [2:0] res;
    int idx;
    res = sel;
    for (int k = n; k >= 1; k--) begin
      idx = (int'(sel) + k) % n;
      if (vld[idx[2:0]]) res = idx[2:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick_lowest.sv
// Combinational lowest-set-bit encoder with an any-set flag.
module rr_pick_lowest #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_in,
  output logic [W-1:0] idx_out,
  output logic         any_out
);

  always_comb begin
    idx_out = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_in[i]) idx_out = W'(i);
    end
  end

  assign any_out = |req_in;

endmodule

// File: rtl/seg_display_scheduler.sv
// Shares one 8-digit seven-segment display among NUM_SRC sources: round-robin dwell,
// manual advance on next_in rising edge, and alert pre-emption with a fixed hold time.
module seg_display_scheduler
  import seg_sched_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int ALERT_CYCLES = 50_000_000,
  parameter int SW           = $clog2(NUM_SRC)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [NUM_SRC*32-1:0] src_val_in,
  input  logic [NUM_SRC-1:0]    src_vld_in,
  input  logic [NUM_SRC-1:0]    alert_in,
  input  logic                  next_in,
  input  logic                  pause_in,
  output logic [31:0]           val_out,
  output logic [SW-1:0]         sel_out,
  output logic                  alert_out,
  output sched_state_t          state_dbg_out
);

  localparam int CNT_MAX = (DWELL_CYCLES > ALERT_CYCLES) ? DWELL_CYCLES : ALERT_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] ALERT_LAST = CW'(ALERT_CYCLES - 1);

  sched_state_t        state_q, state_d;
  logic [SW-1:0]       sel_q, sel_d, ret_q, ret_d;
  logic [CW-1:0]       dwell_q, dwell_d, hold_q, hold_d;
  logic [NUM_SRC-1:0]  pend_q, pend_d, pend_clr;
  logic                next_q, next_d;
  logic [31:0]         val_q, val_d;

  logic [SW-1:0]       vld_pick, pend_pick, rr_from_sel, rr_from_ret;
  logic                vld_any, pend_any, next_rise, sel_vld, ret_vld;

  rr_pick_lowest #(.N(NUM_SRC), .W(SW)) u_pick_vld (
    .req_in (src_vld_in),
    .idx_out(vld_pick),
    .any_out(vld_any)
  );

  rr_pick_lowest #(.N(NUM_SRC), .W(SW)) u_pick_pend (
    .req_in (pend_q),
    .idx_out(pend_pick),
    .any_out(pend_any)
  );

  assign next_rise   = next_in & ~next_q;
  assign sel_vld     = src_vld_in[sel_q];
  assign ret_vld     = src_vld_in[ret_q];
  assign rr_from_sel = SW'(rr_next(8'(src_vld_in), 3'(sel_q), NUM_SRC));
  assign rr_from_ret = SW'(rr_next(8'(src_vld_in), 3'(ret_q), NUM_SRC));

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ret_d    = ret_q;
    dwell_d  = dwell_q;
    hold_d   = hold_q;
    pend_clr = '0;
    case (state_q)
      IDLE: begin
        dwell_d = '0;
        if (pend_any) begin
          state_d  = ALERT;
          ret_d    = sel_q;
          sel_d    = pend_pick;
          pend_clr = NUM_SRC'(1) << pend_pick;
          hold_d   = '0;
        end else if (vld_any) begin
          state_d = SHOW;
          sel_d   = vld_pick;
        end else begin
          sel_d = '0;
        end
      end
      SHOW: begin
        if (!vld_any) begin
          state_d = IDLE;
          sel_d   = '0;
          dwell_d = '0;
        end else if (pend_any) begin
          // Pre-emption wins over any advance due in the same cycle.
          state_d  = ALERT;
          ret_d    = sel_q;
          sel_d    = pend_pick;
          pend_clr = NUM_SRC'(1) << pend_pick;
          hold_d   = '0;
        end else if ((dwell_q == DWELL_LAST && !pause_in) || next_rise || !sel_vld) begin
          sel_d   = rr_from_sel;
          dwell_d = '0;
        end else if (!pause_in && dwell_q != DWELL_LAST) begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      ALERT: begin
        if (hold_q == ALERT_LAST || !sel_vld) begin
          if (pend_any) begin
            sel_d    = pend_pick;
            pend_clr = NUM_SRC'(1) << pend_pick;
            hold_d   = '0;
          end else if (!vld_any) begin
            state_d = IDLE;
            sel_d   = '0;
            dwell_d = '0;
          end else begin
            state_d = SHOW;
            sel_d   = ret_vld ? ret_q : rr_from_ret;
            dwell_d = '0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // Alerts on sources that are not asking for display time are dropped at the door.
  assign pend_d = (pend_q & ~pend_clr) | (alert_in & src_vld_in);
  assign next_d = next_in;
  assign val_d  = (state_q == IDLE) ? 32'h0 : src_val_in[{sel_q, 5'b0} +: 32];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ret_q   <= '0;
      dwell_q <= '0;
      hold_q  <= '0;
      pend_q  <= '0;
      next_q  <= 1'b0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ret_q   <= ret_d;
      dwell_q <= dwell_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      next_q  <= next_d;
      val_q   <= val_d;
    end
  end

  assign val_out       = val_q;
  assign sel_out       = sel_q;
  assign alert_out     = (state_q == ALERT);
  assign state_dbg_out = state_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler: directed vector table, reset/drop sequences,
// and randomized traffic checked cycle-by-cycle against a behavioural model.
module tb_seg_display_scheduler;
  import seg_sched_pkg::*;

  localparam int N = 4;
  localparam int D = 10;
  localparam int A = 5;

  logic         clk = 1'b0;
  logic         rst_in;
  logic [127:0] src_val_in;
  logic [3:0]   src_vld_in;
  logic [3:0]   alert_in;
  logic         next_in;
  logic         pause_in;
  logic [31:0]  val_out;
  logic [1:0]   sel_out;
  logic         alert_out;
  sched_state_t state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seg_display_scheduler #(
    .NUM_SRC(N), .DWELL_CYCLES(D), .ALERT_CYCLES(A)
  ) dut (
    .clk_in       (clk),
    .rst_in       (rst_in),
    .src_val_in   (src_val_in),
    .src_vld_in   (src_vld_in),
    .alert_in     (alert_in),
    .next_in      (next_in),
    .pause_in     (pause_in),
    .val_out      (val_out),
    .sel_out      (sel_out),
    .alert_out    (alert_out),
    .state_dbg_out(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural reference: mode 0=idle, 1=show, 2=alert; tmr is the dwell or hold count.
  int          m_mode = 0, m_cur = 0, m_tmr = 0, m_ret = 0;
  bit [3:0]    m_pend = '0;
  bit          m_prev = 1'b0;
  logic [31:0] m_val = '0;
  bit          model_en = 1'b0;

  function automatic int lowest(input bit [3:0] b);
    for (int i = 0; i < N; i++) if (b[i]) return i;
    return 0;
  endfunction

  function automatic int after(input bit [3:0] v, input int from);
    for (int k = 1; k <= N; k++) if (v[(from + k) % N]) return (from + k) % N;
    return from;
  endfunction

  task serve_lowest_pending();
    m_cur = lowest(m_pend);
    m_pend[m_cur] = 1'b0;
    m_tmr = 0;
    m_mode = 2;
  endtask

  always @(posedge clk) begin
    bit [3:0]    v;
    bit          rise;
    logic [31:0] nv;
    v = src_vld_in;
    if (rst_in) begin
      m_mode = 0; m_cur = 0; m_tmr = 0; m_ret = 0; m_pend = '0; m_val = '0;
      m_prev = 1'b0;
    end else begin
      nv   = (m_mode == 0) ? 32'h0 : src_val_in[m_cur*32 +: 32];
      rise = next_in && !m_prev;
      if (m_mode == 0) begin
        m_tmr = 0;
        if (m_pend != 0) begin m_ret = m_cur; serve_lowest_pending(); end
        else if (v != 0) begin m_mode = 1; m_cur = lowest(v); end
        else m_cur = 0;
      end else if (m_mode == 1) begin
        if (v == 0) begin m_mode = 0; m_cur = 0; m_tmr = 0; end
        else if (m_pend != 0) begin m_ret = m_cur; serve_lowest_pending(); end
        else if ((m_tmr == D - 1 && !pause_in) || rise || !v[m_cur]) begin
          m_cur = after(v, m_cur); m_tmr = 0;
        end else if (!pause_in) m_tmr++;
      end else begin
        if (m_tmr == A - 1 || !v[m_cur]) begin
          if (m_pend != 0) serve_lowest_pending();
          else if (v == 0) begin m_mode = 0; m_cur = 0; m_tmr = 0; end
          else begin
            m_mode = 1; m_tmr = 0;
            m_cur = v[m_ret] ? m_ret : after(v, m_ret);
          end
        end else m_tmr++;
      end
      m_pend = m_pend | (alert_in & v);
      m_val  = nv;
      m_prev = next_in;
    end
  end

  always @(negedge clk) begin
    if (model_en) begin
      check("model_sel", 32'(sel_out), 32'(m_cur));
      check("model_val", val_out, m_val);
      check("model_alert", 32'(alert_out), 32'(m_mode == 2));
    end
  end

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  alert;
    logic        nxt;
    logic        pause;
    int          cyc;
    logic [1:0]  sel;
    logic        alrt;
    logic [31:0] val;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] vld, input logic [3:0] al, input logic nx, input logic pa,
                     input int cyc, input logic [1:0] sel, input logic alrt, input logic [31:0] val);
    vec_t r;
    r.vld = vld; r.alert = al; r.nxt = nx; r.pause = pa; r.cyc = cyc;
    r.sel = sel; r.alrt = alrt; r.val = val;
    tbl.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int alert_hi;

  initial begin
    // Rotation over four sources, then a two-source alert burst.
    add(4'hF, 4'h0, 0, 0,  1, 2'd0, 0, 32'h0);
    add(4'hF, 4'h0, 0, 0,  1, 2'd0, 0, 32'hA0);
    add(4'hF, 4'h0, 0, 0,  9, 2'd1, 0, 32'hA0);
    add(4'hF, 4'h0, 0, 0,  1, 2'd1, 0, 32'hA1);
    add(4'hF, 4'h0, 0, 0, 19, 2'd3, 0, 32'hA2);
    add(4'hF, 4'h0, 0, 0, 10, 2'd0, 0, 32'hA3);
    add(4'hF, 4'h0, 0, 0,  1, 2'd0, 0, 32'hA0);
    add(4'hF, 4'hA, 0, 0,  1, 2'd0, 0, 32'hA0);
    add(4'hF, 4'h0, 0, 0,  1, 2'd1, 1, 32'hA0);
    add(4'hF, 4'h0, 0, 0,  4, 2'd1, 1, 32'hA1);
    add(4'hF, 4'h0, 0, 0,  1, 2'd3, 1, 32'hA1);
    add(4'hF, 4'h0, 0, 0,  5, 2'd0, 0, 32'hA3);
    add(4'hF, 4'h0, 0, 0,  9, 2'd0, 0, 32'hA0);
    add(4'hF, 4'h0, 0, 0,  1, 2'd1, 0, 32'hA0);
    // Manual advance mid-dwell, then on the terminal dwell cycle.
    add(4'hF, 4'h0, 0, 0,  3, 2'd1, 0, 32'hA1);
    add(4'hF, 4'h0, 1, 0,  1, 2'd2, 0, 32'hA1);
    add(4'hF, 4'h0, 0, 0, 10, 2'd3, 0, 32'hA2);
    add(4'hF, 4'h0, 0, 0,  9, 2'd3, 0, 32'hA3);
    add(4'hF, 4'h0, 1, 0,  1, 2'd0, 0, 32'hA3);
    add(4'hF, 4'h0, 0, 0,  1, 2'd0, 0, 32'hA0);
    // Idle, then two-source rotation.
    add(4'h0, 4'h0, 0, 0,  1, 2'd0, 0, 32'hA0);
    add(4'h0, 4'h0, 0, 0,  1, 2'd0, 0, 32'h0);
    add(4'h5, 4'h0, 0, 0,  1, 2'd0, 0, 32'h0);
    add(4'h5, 4'h0, 0, 0, 10, 2'd2, 0, 32'hA0);
    add(4'h5, 4'h0, 0, 0, 10, 2'd0, 0, 32'hA2);
    // Pause with an alert served inside it.
    add(4'h5, 4'h0, 0, 1, 30, 2'd0, 0, 32'hA0);
    add(4'h5, 4'h4, 0, 1,  1, 2'd0, 0, 32'hA0);
    add(4'h5, 4'h0, 0, 1,  1, 2'd2, 1, 32'hA0);
    add(4'h5, 4'h0, 0, 1,  5, 2'd0, 0, 32'hA2);
    add(4'h5, 4'h0, 0, 1, 20, 2'd0, 0, 32'hA0);
    add(4'h5, 4'h0, 0, 0, 10, 2'd2, 0, 32'hA0);
    // Alert source drops out mid-hold.
    add(4'h5, 4'h4, 0, 0,  1, 2'd2, 0, 32'hA2);
    add(4'h5, 4'h0, 0, 0,  1, 2'd2, 1, 32'hA2);
    add(4'h1, 4'h0, 0, 0,  1, 2'd0, 0, 32'hA2);
    add(4'h5, 4'h0, 0, 0,  3, 2'd0, 0, 32'hA0);

    rst_in = 1'b1; src_vld_in = '0; alert_in = '0; next_in = 1'b0; pause_in = 1'b0;
    src_val_in = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_sel", 32'(sel_out), 32'h0);
    check("reset_val", val_out, 32'h0);
    check("reset_alert", 32'(alert_out), 32'h0);
    rst_in = 1'b0;
    model_en = 1'b1;

    foreach (tbl[r]) begin
      src_vld_in = tbl[r].vld; alert_in = tbl[r].alert;
      next_in = tbl[r].nxt; pause_in = tbl[r].pause;
      for (int c = 0; c < tbl[r].cyc; c++) begin
        step();
        if (c == 0) begin alert_in = '0; next_in = 1'b0; end
      end
      check($sformatf("row%0d_sel", r), 32'(sel_out), 32'(tbl[r].sel));
      check($sformatf("row%0d_alert", r), 32'(alert_out), 32'(tbl[r].alrt));
      check($sformatf("row%0d_val", r), val_out, tbl[r].val);
    end

    // Reset lands while an alert is pending: nothing may survive it.
    src_vld_in = 4'hF; alert_in = 4'h8;
    step();
    alert_in = '0; rst_in = 1'b1;
    step();
    check("midrst_sel", 32'(sel_out), 32'h0);
    check("midrst_val", val_out, 32'h0);
    check("midrst_alert", 32'(alert_out), 32'h0);
    rst_in = 1'b0;
    alert_hi = 0;
    for (int c = 0; c < 15; c++) begin step(); if (alert_out) alert_hi++; end
    check("no_alert_after_reset", 32'(alert_hi), 32'h0);

    // Alerts on sources that are not valid are dropped.
    src_vld_in = 4'h5; alert_in = 4'hA;
    step();
    alert_in = '0;
    alert_hi = 0;
    for (int c = 0; c < 12; c++) begin step(); if (alert_out) alert_hi++; end
    check("invalid_alert_dropped", 32'(alert_hi), 32'h0);

    for (int c = 0; c < 3000; c++) begin
      int k;
      rst_in = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 19) == 0) src_vld_in = 4'($urandom_range(0, 15));
      alert_in = ($urandom_range(0, 14) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      if ($urandom_range(0, 7) == 0) next_in = ~next_in;
      if ($urandom_range(0, 24) == 0) pause_in = ~pause_in;
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 3);
        src_val_in[k*32 +: 32] = $urandom();
      end
      step();
    end

    model_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
